cache_miss_arb: RTL

Miss/writeback arbiter between the instruction cache and data cache of one core. It accepts line-refill requests from both caches, plus dirty-victim writebacks from the data cache, and serialises them onto the single beat-oriented DMA port. Refill data is streamed back to the requesting cache. Sits between the cache pair and the DMA engine; it is the only master on that DMA port.

---
 rtl/cache_miss_arb_pkg.sv | 31 +++
 rtl/cache_miss_arb_if.sv | 60 ++++++
 rtl/cache_miss_arb_rr_arb2.sv | 42 ++++
 rtl/cache_miss_arb.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cache_miss_arb_pkg.sv
// ============================================================================
// Module  : cache_pkg
// Purpose : Shared types and constants for the cache miss/writeback arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam int unsigned c_line_words = 8;
    localparam int unsigned c_idx_w      = $clog2(c_line_words);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_FILL = 3'd1,
        D_WB   = 3'd2,
        D_FILL = 3'd3,
        DONE   = 3'd4
    } arb_state_t;

    // Line base: clear the word-index and byte-offset bits of a byte address.
    function automatic logic [31:0] line_base(input logic [31:0] addr,
                                              input int unsigned words);
        logic [31:0] mask;
        mask = (words << 2) - 32'd1;
        return addr & ~mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_miss_arb_if.sv
// ============================================================================
// Module  : cache_miss_arb_if
// Purpose : Cache-pair and DMA-port signal bundle for cache_miss_arb.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_miss_arb_if
    import cache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = c_line_words
);
    localparam int unsigned c_if_idx_w = $clog2(LINE_WORDS);

    // I-cache side
    logic                  i_req;
    logic [31:0]           i_addr;
    logic                  i_done;
    logic                  i_fault;
    // D-cache side
    logic                  d_req;
    logic                  d_wb;
    logic [31:0]           d_wb_addr;
    logic [31:0]           d_addr;
    logic [c_if_idx_w-1:0] d_wb_idx;
    logic [31:0]           d_wb_data;
    logic                  d_done;
    logic                  d_fault;
    // Refill return path
    logic [31:0]           fill_data;
    logic [c_if_idx_w-1:0] fill_idx;
    logic                  i_fill_we;
    logic                  d_fill_we;
    // DMA port
    logic                  dma_req;
    logic                  dma_we;
    logic [31:0]           dma_addr;
    logic [31:0]           dma_wdata;
    logic                  dma_ack;
    logic [31:0]           dma_rdata;

    modport master (
        input  i_req, i_addr, d_req, d_wb, d_wb_addr, d_addr, d_wb_data,
               dma_ack, dma_rdata,
        output i_done, i_fault, d_wb_idx, d_done, d_fault,
               fill_data, fill_idx, i_fill_we, d_fill_we,
               dma_req, dma_we, dma_addr, dma_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_wb, d_wb_addr, d_addr, d_wb_data,
               dma_ack, dma_rdata,
        input  i_done, i_fault, d_wb_idx, d_done, d_fault,
               fill_data, fill_idx, i_fill_we, d_fill_we,
               dma_req, dma_we, dma_addr, dma_wdata
    );

endinterface

`default_nettype wire

// File: rtl/cache_miss_arb_rr_arb2.sv
// ============================================================================
// Module  : rr_arb2
// Purpose : Two-input round-robin picker (bit 0 = I, bit 1 = D) holding last_d.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import cache_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] reqs,
    input  wire logic       upd,
    input  wire logic       upd_d,
    output logic      [1:0] grant
);

    logic r_last_d;

    // Reset to 1 so the I side wins the very first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b1;
        end else if (upd) begin
            r_last_d <= upd_d;
        end
    end

    always_comb begin
        grant = 2'b00;
        case (reqs)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last_d ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cache_miss_arb.sv
// ============================================================================
// Module  : cache_miss_arb
// Purpose : Serialises I/D line refills and D victim writebacks onto one
//           beat-oriented DMA port. Optional address segment check is enabled
//           by defining CACHE_ARB_SEGCHK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_miss_arb
    import cache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = c_line_words,
    parameter logic [31:0] MEM_TOP    = 32'h1000_0000
)(
    input  wire logic         clk,
    input  wire logic         rst,
    cache_miss_arb_if.master  bus
);

    localparam int unsigned c_idx_w = $clog2(LINE_WORDS);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [c_idx_w-1:0]  r_beat;
    logic [c_idx_w-1:0]  w_beat_nxt;
    logic                r_owner_d;
    logic                w_owner_d_nxt;
    logic                r_fault;
    logic                w_fault_nxt;
    logic [1:0]          w_grant;
    logic                w_last_beat;
    logic                w_i_bad;
    logic                w_d_bad;
    logic [31:0]         w_base;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .reqs  ({bus.d_req, bus.i_req}),
        .upd   (r_state == DONE),
        .upd_d (r_owner_d),
        .grant (w_grant)
    );

`ifdef CACHE_ARB_SEGCHK_EN
    // A D transaction faults as a whole if either of its lines is out of range.
    assign w_i_bad = (bus.i_addr >= MEM_TOP);
    assign w_d_bad = (bus.d_addr >= MEM_TOP) ||
                     (bus.d_wb && (bus.d_wb_addr >= MEM_TOP));
`else
    logic w_unused_mem_top;
    assign w_unused_mem_top = ^MEM_TOP;
    assign w_i_bad          = 1'b0;
    assign w_d_bad          = 1'b0;
`endif

    assign w_last_beat = bus.dma_ack && (r_beat == c_idx_w'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_beat    <= '0;
            r_owner_d <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_beat    <= w_beat_nxt;
            r_owner_d <= w_owner_d_nxt;
            r_fault   <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat;
        w_owner_d_nxt = r_owner_d;
        w_fault_nxt   = r_fault;
        w_base        = '0;
        bus.i_done    = 1'b0;
        bus.i_fault   = 1'b0;
        bus.d_done    = 1'b0;
        bus.d_fault   = 1'b0;
        bus.d_wb_idx  = '0;
        bus.fill_data = '0;
        bus.fill_idx  = '0;
        bus.i_fill_we = 1'b0;
        bus.d_fill_we = 1'b0;
        bus.dma_req   = 1'b0;
        bus.dma_we    = 1'b0;
        bus.dma_addr  = '0;
        bus.dma_wdata = '0;

        case (r_state)
            IDLE: begin
                w_beat_nxt  = '0;
                w_fault_nxt = 1'b0;
                if (w_grant[0]) begin
                    w_owner_d_nxt = 1'b0;
                    if (w_i_bad) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = I_FILL;
                    end
                end else if (w_grant[1]) begin
                    w_owner_d_nxt = 1'b1;
                    if (w_d_bad) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = DONE;
                    end else if (bus.d_wb) begin
                        w_state_nxt = D_WB;
                    end else begin
                        w_state_nxt = D_FILL;
                    end
                end
            end

            I_FILL: begin
                w_base        = line_base(bus.i_addr, LINE_WORDS);
                bus.dma_req   = 1'b1;
                bus.dma_addr  = w_base + 32'({r_beat, 2'b00});
                if (bus.dma_ack) begin
                    bus.fill_data = bus.dma_rdata;
                    bus.fill_idx  = r_beat;
                    bus.i_fill_we = 1'b1;
                    w_beat_nxt    = r_beat + c_idx_w'(1);
                end
                if (w_last_beat) begin
                    w_beat_nxt  = '0;
                    w_state_nxt = DONE;
                end
            end

            D_WB: begin
                w_base        = line_base(bus.d_wb_addr, LINE_WORDS);
                bus.dma_req   = 1'b1;
                bus.dma_we    = 1'b1;
                bus.dma_addr  = w_base + 32'({r_beat, 2'b00});
                bus.d_wb_idx  = r_beat;
                bus.dma_wdata = bus.d_wb_data;
                if (bus.dma_ack) begin
                    w_beat_nxt = r_beat + c_idx_w'(1);
                end
                // Victim fully written: refill immediately follows on the same grant.
                if (w_last_beat) begin
                    w_beat_nxt  = '0;
                    w_state_nxt = D_FILL;
                end
            end

            D_FILL: begin
                w_base        = line_base(bus.d_addr, LINE_WORDS);
                bus.dma_req   = 1'b1;
                bus.dma_addr  = w_base + 32'({r_beat, 2'b00});
                if (bus.dma_ack) begin
                    bus.fill_data = bus.dma_rdata;
                    bus.fill_idx  = r_beat;
                    bus.d_fill_we = 1'b1;
                    w_beat_nxt    = r_beat + c_idx_w'(1);
                end
                if (w_last_beat) begin
                    w_beat_nxt  = '0;
                    w_state_nxt = DONE;
                end
            end

            DONE: begin
                bus.i_done  = ~r_owner_d;
                bus.i_fault = ~r_owner_d & r_fault;
                bus.d_done  = r_owner_d;
                bus.d_fault = r_owner_d & r_fault;
                w_beat_nxt  = '0;
                w_state_nxt = IDLE;
            end

            default: begin
                w_beat_nxt  = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
